// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared constants for the sequential shift-and-add multiplier:
//   - ALU control words (zx,nx,zy,ny,f,no packed MSB..LSB)
//   - multiplier FSM state encoding
//   - datapath width and number of multiplier bit steps
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

   localparam int DATA_W    = 16;
   localparam int MUL_STEPS = 16;

   // {zx, nx, zy, ny, f, no}
   localparam logic [5:0] ALU_OP_ADD    = 6'b000010;  // x + y
   localparam logic [5:0] ALU_OP_PASS_X = 6'b001100;  // x

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DBL  = 2'd2,
      DONE = 2'd3
   } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
// Request/result bundle between a requester and alu_mul_seq.
//   start   : request pulse, sampled only while busy is low
//   a, b    : multiplicand / multiplier, captured on acceptance
//   busy    : operation in progress
//   done    : one-cycle pulse, product/zr/ng valid from this cycle on
//   product : low 16 bits of a*b, held until the next done
//   zr, ng  : product == 0, product[15]
// Modports: master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface alu_mul_seq_if;
   import alu_mul_seq_pkg::*;

   logic              start;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] product;
   logic              zr;
   logic              ng;

   modport master (
      output start, a, b,
      input  busy, done, product, zr, ng
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, zr, ng
   );

endinterface

// File: rtl/alu_mul_seq_alu.sv
// -----------------------------------------------------------------------------
// ALU
// Purely combinational 16-bit ALU with the classic six control bits:
//   x, y           : operands
//   zx, nx         : zero x, then invert x
//   zy, ny         : zero y, then invert y
//   f              : 1 = x + y (carry out dropped), 0 = x & y
//   no             : invert the result
//   out            : result
// -----------------------------------------------------------------------------
module ALU
   import alu_mul_seq_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              zx,
   input  logic              nx,
   input  logic              zy,
   input  logic              ny,
   input  logic              f,
   input  logic              no,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

   always_comb begin
      x_z   = zx ? '0 : x;
      x_n   = nx ? ~x_z : x_z;
      y_z   = zy ? '0 : y;
      y_n   = ny ? ~y_z : y_z;
      f_out = f ? (x_n + y_n) : (x_n & y_n);
      out   = no ? ~f_out : f_out;
   end

endmodule

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle 16x16 multiplier (low 16 bits of the product) built by sequencing
// one shared ALU through shift-and-add using only its x+y function.
// Each multiplier bit costs two cycles: ADD (acc += m when r[0]) and
// DBL (m += m, r >>= 1). Result appears with a one-cycle done pulse 33 cycles
// after start is accepted.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : alu_mul_seq_if.slave (start/a/b in, busy/done/product/zr/ng out)
// Build option:
//   ALU_MUL_EARLY_EXIT_EN : when defined, ADD finishes early once the remaining
//                           multiplier bits are all zero.
// -----------------------------------------------------------------------------
module alu_mul_seq
   import alu_mul_seq_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   alu_mul_seq_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_ADD  = ADD;
   localparam logic [1:0] ST_DBL  = DBL;
   localparam logic [1:0] ST_DONE = DONE;
   localparam logic [3:0] LAST_I  = 4'(MUL_STEPS - 1);

   logic [1:0]        state;
   logic [DATA_W-1:0] m;
   logic [DATA_W-1:0] r;
   logic [DATA_W-1:0] acc;
   logic [3:0]        i;

   logic [DATA_W-1:0] alu_x;
   logic [DATA_W-1:0] alu_out;
   logic [5:0]        alu_ctl;

   // x carries acc for accumulation and m for doubling; y is always m.
   // Outside the compute states the ALU is parked on pass-x.
   always_comb begin
      alu_x   = (state == ST_DBL) ? m : acc;
      alu_ctl = (state == ST_ADD || state == ST_DBL) ? ALU_OP_ADD : ALU_OP_PASS_X;
   end

   ALU u_alu (
      .x   (alu_x),
      .y   (m),
      .zx  (alu_ctl[5]),
      .nx  (alu_ctl[4]),
      .zy  (alu_ctl[3]),
      .ny  (alu_ctl[2]),
      .f   (alu_ctl[1]),
      .no  (alu_ctl[0]),
      .out (alu_out)
   );

   assign bus.busy = (state == ST_ADD) || (state == ST_DBL);
   assign bus.done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         m           <= '0;
         r           <= '0;
         acc         <= '0;
         i           <= '0;
         bus.product <= '0;
         bus.zr      <= 1'b1;
         bus.ng      <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a new request just like IDLE for back-to-back use
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  m     <= bus.a;
                  r     <= bus.b;
                  acc   <= '0;
                  i     <= '0;
                  state <= ST_ADD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ADD: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
               // no multiplier bits left: acc already holds the final sum
               if (r == '0) begin
                  bus.product <= acc;
                  bus.zr      <= (acc == '0);
                  bus.ng      <= acc[DATA_W-1];
                  state       <= ST_DONE;
               end else begin
                  if (r[0]) acc <= alu_out;
                  state <= ST_DBL;
               end
`else
               if (r[0]) acc <= alu_out;
               state <= ST_DBL;
`endif
            end
            ST_DBL: begin
               m <= alu_out;
               r <= r >> 1;
               if (i == LAST_I) begin
                  bus.product <= acc;
                  bus.zr      <= (acc == '0);
                  bus.ng      <= acc[DATA_W-1];
                  state       <= ST_DONE;
               end else begin
                  i     <= i + 4'd1;
                  state <= ST_ADD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16x16 multiplier that sequences a single ALU instance through shift-and-add using only the ALU's `x+y` function. A requester pulses `start` with two operands. The block returns the low 16 bits of the two's-complement product, plus zero and negative flags, after a fixed 32-cycle compute phase. It sits beside the CPU datapath as the first multi-cycle arithmetic helper and reuses the existing ALU rather than adding a hardware multiplier.

## Interface
- No parameters. Width is fixed at 16.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request. Sampled only when `busy`=0.
- `a`  input  16  multiplicand. Captured when `start` is accepted.
- `b`  input  16  multiplier. Captured when `start` is accepted.
- `busy`  output  1  high while computing.
- `done`  output  1  one-cycle pulse. `product`, `zr` and `ng` are updated in the same cycle.
- `product`  output  16  low 16 bits of a*b. Held until the next `done`.
- `zr`  output  1  `product`==0. Registered together with `product`.
- `ng`  output  1  `product[15]`. Registered together with `product`.

## Operation
- Registers:
  - `m`: shifted multiplicand, 16 bits.
  - `r`: multiplier shift register, 16 bits.
  - `acc`: accumulator, 16 bits.
  - `i`: bit counter, 4 bits.
  - `state`.
- States and transitions:
  - `IDLE`: `start` loads m=a, r=b, acc=0, i=0, then goes to `ADD`.
  - `ADD`: ALU computes acc+m (zx=nx=zy=ny=0, f=1, no=0). If r[0]=1, acc takes the ALU output; otherwise acc holds. Next state is `DBL`.
  - `DBL`: ALU computes m+m with both ALU inputs driven by m, same control bits as `ADD`. m takes the ALU output and r shifts right logically by 1. If i=15, next state is `DONE`; otherwise i increments and the next state is `ADD`.
  - `DONE`: `done`=1 and `busy`=0. If `start`=1, the operands are loaded and the next state is `ADD` (back-to-back operation). Otherwise the next state is `IDLE`.
- On the transition into `DONE`, product<=acc, zr<=(acc==0) and ng<=acc[15].
- Arithmetic:
  - All sums wrap modulo 2^16 and carry out is discarded.
  - The result equals the low 16 bits of the signed and of the unsigned product.
- `start` while `busy`=1 is ignored. Operands are not re-captured.
- `a`/`b` changes after acceptance have no effect.
- Reset values:
  - `state`=`IDLE`, `busy`=0, `done`=0.
  - `product`=0, `zr`=1, `ng`=0.
  - m, r, acc, i = 0.
- Reset mid-operation aborts the operation. No `done` pulse is produced and `product` returns to 0.

## Timing
- `start` is accepted at the rising edge ending cycle N.
- `busy`=1 in cycles N+1..N+32:
  - `ADD` runs on the odd offsets.
  - `DBL` runs on the even offsets.
- `done`=1 in cycle N+33, and new `product`/`zr`/`ng` are visible in N+33.
- Fixed latency is 33 cycles from acceptance to `done`. Throughput is one result per 33 cycles with back-to-back `start`.
- The ALU path is combinational within one cycle, and no ALU output is registered inside the ALU.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN`
  - Defined: in `ADD`, if r==0 the block skips the ALU write and goes straight to `DONE`. Latency becomes 2·(index of highest set bit of b + 1) + 2 cycles to `done`. If b=0, `done` is in N+2. If b[15]=1, `done` is in N+33.
  - Undefined: fixed 33-cycle latency for all operands.

## Structure
- Shared package contents:
  - 6-bit ALU control constants `ALU_OP_ADD`=6'b000010 and `ALU_OP_PASS_X`=6'b001100.
  - State enum `IDLE`/`ADD`/`DBL`/`DONE`.
  - `MUL_STEPS`=16.
- Sub-module: one instance of the existing `ALU`.
- The ALU operand muxing (acc/m on x, m on y) and the control sequencing live in this module. No further sub-modules.

## Test plan
- a=3, b=5, `start` in cycle N:
  - `busy` is 1 for N+1..N+32.
  - `done` is 1 in N+33 only, with product=0x000F, zr=0, ng=0.
- a=0xFFFE (-2), b=7 -> product=0xFFF2 (-14), ng=1, zr=0.
- a=0x0100, b=0x0100 -> product=0x0000 (wrap), zr=1, ng=0.
- Pulse `start` with a=9, b=9 at N+5 during a busy operation (3*5) -> result is 0x000F at N+33, and no second `done` follows.
- Assert `reset` in cycle N+10 of an operation:
  - Next cycle: `busy`=0 and product=0.
  - No `done` pulse.
  - A new start with a=2, b=3 then yields 0x0006.
- `start` held high in the `DONE` cycle with a=4, b=4:
  - The next result is 0x0010, with `done` 33 cycles later.
  - With `ALU_MUL_EARLY_EXIT_EN` defined, b=1, a=0x1234: `done` in N+4 with product=0x1234.
